// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART core:
//   PAR_NONE / PAR_ODD / PAR_EVEN - parity modes
//   tx_state_e / rx_state_e       - TX and RX FSM states
//   calc_div()                    - clk cycles per oversample tick
//   parity_bit()                  - parity bit for a data word
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   // round(clk_hz / (baud * os)), never below 1
   function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
      longint d;
      longint q;
      d = baud * os;
      q = (clk_hz + d / 2) / d;
      return (q < 1) ? 1 : int'(q);
   endfunction

   // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [8:0] d, input int mode);
      return (mode == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Oversample tick generator with bit-phase tracking.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart at phase 0 of a new bit
//   tick       : one pulse every DIV clk
//   bit_mid    : tick that ends the first half of a bit (OVERSAMPLE/2 ticks in)
//   bit_end    : tick that ends a full bit (OVERSAMPLE ticks in)
module uart_baud_gen #(
   parameter int DIV        = 27,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick,
   output logic bit_mid,
   output logic bit_end
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OW = $clog2(OVERSAMPLE);

   logic [DW-1:0] div_q;
   logic [OW-1:0] os_q;

   assign tick    = (div_q == DW'(DIV - 1));
   assign bit_mid = tick && (os_q == OW'(OVERSAMPLE / 2 - 1));
   assign bit_end = tick && (os_q == OW'(OVERSAMPLE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         os_q  <= '0;
      end else if (clr) begin
         div_q <= '0;
         os_q  <= '0;
      end else if (tick) begin
         div_q <= '0;
         os_q  <= bit_end ? '0 : os_q + OW'(1);
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

endmodule

// File: rtl/uart_core.sv
// uart_core
// Full-duplex parametrised UART, valid/ready on both sides.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   tx_data, tx_valid, tx_ready : word to send; accepted when valid & ready
//   tx                          : serial out, idle high
//   rx                          : serial in (asynchronous, synchronised here)
//   rx_data, rx_valid, rx_ready : received word, held until valid & ready
//   rx_parity_err, rx_frame_err : error flags belonging to rx_data
//   rx_overrun                  : 1-cycle pulse, frame dropped because rx_valid was pending
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

   // ---------------- TX ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [3:0]           tx_cnt_q, tx_cnt_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;
   logic                 tx_accept, tx_last_stop, tx_bit_end;
   logic                 tx_tick_unused, tx_mid_unused;

   uart_baud_gen #(.DIV(DIV), .OVERSAMPLE(OVERSAMPLE)) u_tx_baud (
      .clk(clk), .rst_n(rst_n), .clr(tx_accept),
      .tick(tx_tick_unused), .bit_mid(tx_mid_unused), .bit_end(tx_bit_end)
   );

   // Ready also in the final cycle of the last stop bit so back-to-back words have no gap.
   assign tx_last_stop = (tx_state_q == TX_STOP) && tx_bit_end && (tx_cnt_q == 4'(STOP_BITS - 1));
   assign tx_ready     = (tx_state_q == TX_IDLE) || tx_last_stop;
   assign tx_accept    = tx_valid && tx_ready;
   assign tx           = tx_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      case (tx_state_q)
         TX_IDLE: tx_d = 1'b1;
         TX_START: if (tx_bit_end) begin
            tx_state_d = TX_DATA;
            tx_d       = tx_shift_q[0];
            tx_cnt_d   = '0;
         end
         TX_DATA: if (tx_bit_end) begin
            if (tx_cnt_q == 4'(DATA_BITS - 1)) begin
               tx_cnt_d = '0;
               if (PARITY != PAR_NONE) begin
                  tx_state_d = TX_PARITY;
                  tx_d       = tx_par_q;
               end else begin
                  tx_state_d = TX_STOP;
                  tx_d       = 1'b1;
               end
            end else begin
               tx_shift_d = tx_shift_q >> 1;
               tx_d       = tx_shift_q[1];
               tx_cnt_d   = tx_cnt_q + 4'd1;
            end
         end
         TX_PARITY: if (tx_bit_end) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
            tx_cnt_d   = '0;
         end
         TX_STOP: if (tx_bit_end) begin
            if (tx_last_stop) tx_state_d = TX_IDLE;
            else              tx_cnt_d   = tx_cnt_q + 4'd1;
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
         end
      endcase
      // An accept overrides everything: it can happen in IDLE or at the end of the last stop bit.
      if (tx_accept) begin
         tx_state_d = TX_START;
         tx_shift_d = tx_data;
         tx_par_d   = parity_bit(9'(tx_data), PARITY);
         tx_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_cnt_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
      end
   end

   // ---------------- RX ----------------
   rx_state_e            rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [3:0]           rx_cnt_q, rx_cnt_d;
   logic                 rx_par_bit_q, rx_par_bit_d;
   logic                 rx_meta_q, rx_sync_q;
   logic                 rx_done, rx_handshake, rx_bit_mid;
   logic                 rx_tick_unused, rx_end_unused;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_ovr_q, rx_ovr_d;

   // Held in reset while idle so the first bit_mid lands in the middle of the start bit.
   uart_baud_gen #(.DIV(DIV), .OVERSAMPLE(OVERSAMPLE)) u_rx_baud (
      .clk(clk), .rst_n(rst_n), .clr(rx_state_q == RX_IDLE),
      .tick(rx_tick_unused), .bit_mid(rx_bit_mid), .bit_end(rx_end_unused)
   );

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_shift_d   = rx_shift_q;
      rx_cnt_d     = rx_cnt_q;
      rx_par_bit_d = rx_par_bit_q;
      rx_done      = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_sync_q) rx_state_d = RX_START;
         RX_START: if (rx_bit_mid) begin
            // line already back high at mid-start: treat as a glitch
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            rx_cnt_d   = '0;
         end
         RX_DATA: if (rx_bit_mid) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_cnt_q == 4'(DATA_BITS - 1))
               rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
               rx_cnt_d = rx_cnt_q + 4'd1;
         end
         RX_PARITY: if (rx_bit_mid) begin
            rx_par_bit_d = rx_sync_q;
            rx_state_d   = RX_STOP;
         end
         RX_STOP: if (rx_bit_mid) begin
            rx_done    = 1'b1;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
         end
         RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign rx_handshake = rx_valid_q && rx_ready;

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_ovr_d   = 1'b0;
      if (rx_done && (!rx_valid_q || rx_handshake)) begin
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
         rx_perr_d  = (PARITY != PAR_NONE) &&
                      (rx_par_bit_q != parity_bit(9'(rx_shift_q), PARITY));
         rx_ferr_d  = !rx_sync_q;
      end else begin
         if (rx_handshake) rx_valid_d = 1'b0;
         if (rx_done)      rx_ovr_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_shift_q   <= '0;
         rx_cnt_q     <= '0;
         rx_par_bit_q <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_perr_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
         rx_ovr_q     <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rx_state_q   <= rx_state_d;
         rx_shift_q   <= rx_shift_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_par_bit_q <= rx_par_bit_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_perr_q    <= rx_perr_d;
         rx_ferr_q    <= rx_ferr_d;
         rx_ovr_q     <= rx_ovr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core
// Directed bench: default 8N1 instance (DIV=27, 432 clk/bit) plus a
// 7E1 instance (DIV=2, 32 clk/bit) for parity checks.
module tb_uart_core;

   localparam int BIT    = 432;
   localparam int FRAME  = 10 * BIT;                             // 4320
   localparam int RX_LAT = 2 + (16 / 2 + (8 + 0 + 1) * 16) * 27 + 1; // 4107
   localparam int PBIT   = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready_w, tx_w;
   logic       rx_drv, loop_en, rx_line;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready, perr, ferr, ovr;

   logic [6:0] p_tx_data;
   logic       p_tx_valid, p_tx_ready_unused, p_tx_unused;
   logic       p_rx;
   logic [6:0] p_rx_data;
   logic       p_rx_valid, p_rx_ready, p_perr, p_ferr, p_ovr_unused;

   assign rx_line = loop_en ? tx_w : rx_drv;

   uart_core u_dut (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_w), .tx(tx_w),
      .rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_parity_err(perr), .rx_frame_err(ferr), .rx_overrun(ovr)
   );

   uart_core #(.CLK_HZ(3_686_400), .DATA_BITS(7), .PARITY(2)) u_par (
      .clk(clk), .rst_n(rst_n),
      .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready_unused), .tx(p_tx_unused),
      .rx(p_rx), .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_ready(p_rx_ready),
      .rx_parity_err(p_perr), .rx_frame_err(p_ferr), .rx_overrun(p_ovr_unused)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ovr_cnt = 0;
   int t0, t1, t2, n, rdy, base;
   logic prev;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (ovr === 1'b1) ovr_cnt <= ovr_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
      $display("check %-20s observed=%0h expected=%0h", tag, got, exp);
   endtask

   // bits[0] goes out first; each bit held for blen clk
   task automatic send_frame(input bit par_dut, input logic [15:0] bits, input int nbits, input int blen);
      for (int i = 0; i < nbits; i++) begin
         if (par_dut) p_rx = bits[i];
         else         rx_drv = bits[i];
         repeat (blen) @(negedge clk);
      end
   endtask

   task automatic rx_ack();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
      rx_ready = 1'b0; p_tx_data = '0; p_tx_valid = 1'b0; p_rx = 1'b1; p_rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_w, 1);
      check("rst_tx_ready", tx_ready_w, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_perr", perr, 0);
      check("rst_ferr", ferr, 0);
      check("rst_ovr", ovr, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // loopback 0xA5
      loop_en = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0; t0 = cyc;
      check("lb_tx_fall", tx_w, 0);
      check("lb_tx_busy", tx_ready_w, 0);
      n = 0;
      while (tx_w === 1'b0 && n < 2000) begin @(negedge clk); n++; end
      check("lb_start_len", n, BIT);
      n = 0;
      while (rx_valid !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
      check("lb_rx_latency", cyc - t0, RX_LAT);
      check("lb_rx_data", rx_data, 8'hA5);
      check("lb_perr", perr, 0);
      check("lb_ferr", ferr, 0);
      n = 0;
      while (tx_ready_w !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      check("lb_tx_ready_rise", cyc - t0, FRAME - 1);
      rx_ack();
      check("lb_rx_valid_clr", rx_valid, 0);
      loop_en = 1'b0;

      // back-to-back 0x00 then 0xFF with tx_valid held
      @(negedge clk);
      tx_data = 8'h00; tx_valid = 1'b1;
      @(negedge clk);
      t1 = cyc; tx_data = 8'hFF;
      check("b2b_tx_fall", tx_w, 0);
      rdy = 0; n = 0; t2 = 0; prev = tx_w;
      while (n < 5000 && t2 == 0) begin
         @(negedge clk); n++;
         if (tx_ready_w === 1'b1) rdy++;
         if (prev === 1'b1 && tx_w === 1'b0) t2 = cyc;
         prev = tx_w;
      end
      tx_valid = 1'b0;
      check("b2b_start_gap", t2 - t1, FRAME);
      check("b2b_ready_cycles", rdy, 1);
      repeat (BIT + BIT / 2) @(negedge clk);
      check("b2b_ff_bit0", tx_w, 1);
      n = 0;
      while (tx_ready_w !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      check("b2b_ready_rise2", cyc - t2, FRAME - 1);

      // 7E1: 0x13 with correct parity 1, then 0x55 with wrong parity 1
      send_frame(1'b1, {6'b0, 1'b1, 1'b1, 7'h13, 1'b0}, 10, PBIT);
      check("par_ok_valid", p_rx_valid, 1);
      check("par_ok_data", p_rx_data, 7'h13);
      check("par_ok_perr", p_perr, 0);
      check("par_ok_ferr", p_ferr, 0);
      p_rx_ready = 1'b1; @(negedge clk); p_rx_ready = 1'b0;
      send_frame(1'b1, {6'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, PBIT);
      check("par_bad_valid", p_rx_valid, 1);
      check("par_bad_data", p_rx_data, 7'h55);
      check("par_bad_perr", p_perr, 1);
      check("par_bad_ferr", p_ferr, 0);
      p_rx_ready = 1'b1; @(negedge clk); p_rx_ready = 1'b0;

      // break: line low for 20 bit times
      rx_drv = 1'b0;
      repeat (20 * BIT) @(negedge clk);
      check("brk_valid", rx_valid, 1);
      check("brk_data", rx_data, 8'h00);
      check("brk_ferr", ferr, 1);
      rx_ack();
      repeat (2 * BIT) @(negedge clk);
      check("brk_no_second", rx_valid, 0);
      rx_drv = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      send_frame(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, BIT);
      repeat (10) @(negedge clk);
      check("3c_valid", rx_valid, 1);
      check("3c_data", rx_data, 8'h3C);
      check("3c_ferr", ferr, 0);
      rx_ack();

      // 4-tick glitch, then 0x81
      rx_drv = 1'b0;
      repeat (4 * 27) @(negedge clk);
      rx_drv = 1'b1;
      repeat (12 * BIT) @(negedge clk);
      check("glitch_no_valid", rx_valid, 0);
      send_frame(1'b0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, BIT);
      repeat (10) @(negedge clk);
      check("81_valid", rx_valid, 1);
      check("81_data", rx_data, 8'h81);
      check("81_ferr", ferr, 0);
      rx_ack();

      // overrun: 0x11 then 0x22 without acknowledging
      base = ovr_cnt;
      send_frame(1'b0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, BIT);
      repeat (BIT) @(negedge clk);
      send_frame(1'b0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, BIT);
      repeat (10) @(negedge clk);
      check("ovr_valid", rx_valid, 1);
      check("ovr_data_kept", rx_data, 8'h11);
      check("ovr_pulses", ovr_cnt - base, 1);
      check("ovr_low_after", ovr, 0);

      // reset in the middle of a TX frame
      tx_data = 8'h00; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (1000) @(negedge clk);
      check("mid_tx_low", tx_w, 0);
      check("mid_tx_busy", tx_ready_w, 0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx", tx_w, 1);
      check("rst_mid_ready", tx_ready_w, 1);
      check("rst_mid_rx_valid", rx_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_tx", tx_w, 1);
      check("post_rst_ready", tx_ready_w, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
